// File: rtl/mod_demod_pkg.sv
// Shared types and defaults for the mod/demod serial framing blocks.
// The receiver FSM states and default frame geometry live here.
package mod_demod_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } rx_state_t;

    localparam int          FRAME_W_DEF  = 21;
    localparam logic [7:0]  PREAMBLE_DEF = 8'hA5;
    localparam int          CNT_W        = 5;

endpackage

// File: rtl/frame_out_buf.sv
// Single-entry valid/ready holding register for received frames.
// A new frame overwrites only when the slot is empty or being drained this cycle.
module frame_out_buf #(
    parameter int FRAME_W = 21
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    input  logic [FRAME_W-1:0] load_data,
    input  logic               frame_ready,
    output logic [FRAME_W-1:0] frame_out,
    output logic               frame_valid,
    output logic               overrun
);

    logic consume;

    assign consume = frame_valid & frame_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_out   <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load_valid) begin
                if (!frame_valid || consume) begin
                    frame_out   <= load_data;
                    frame_valid <= 1'b1;
                end else begin
                    // Slot full and not draining: keep the older frame.
                    overrun <= 1'b1;
                end
            end else if (consume) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/demod_frame_rx.sv
// Serial frame receiver: hunts for a preamble, collects an MSB-first payload,
// checks even parity and hands good frames to a single-entry output buffer.
//
// state  | meaning
// HUNT   | shifting bits looking for the preamble
// DATA   | collecting FRAME_W payload bits
// PARITY | waiting for the even-parity bit
module demod_frame_rx
    import mod_demod_pkg::*;
#(
    parameter int               FRAME_W  = FRAME_W_DEF,
    parameter int               PRE_W    = 8,
    parameter logic [PRE_W-1:0] PREAMBLE = PREAMBLE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic [FRAME_W-1:0] frame_out,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               parity_err,
    output logic               overrun
);

    rx_state_t          state, state_nx;
    logic [PRE_W-1:0]   pre_reg, pre_nx, pre_shift;
    logic [FRAME_W-1:0] payload, payload_nx;
    logic [CNT_W-1:0]   bit_cnt, cnt_nx;
    logic               par_err_nx;
    logic               load_good;

    assign pre_shift = {pre_reg[PRE_W-2:0], bit_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            pre_reg    <= '0;
            payload    <= '0;
            bit_cnt    <= '0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_nx;
            pre_reg    <= pre_nx;
            payload    <= payload_nx;
            bit_cnt    <= cnt_nx;
            parity_err <= par_err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pre_nx     = pre_reg;
        payload_nx = payload;
        cnt_nx     = bit_cnt;
        par_err_nx = 1'b0;
        load_good  = 1'b0;
        if (bit_valid) begin
            case (state)
                HUNT: begin
                    pre_nx = pre_shift;
                    if (pre_shift == PREAMBLE) begin
                        state_nx = DATA;
                        cnt_nx   = '0;
                    end
                end
                DATA: begin
                    payload_nx = {payload[FRAME_W-2:0], bit_in};
                    if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                        state_nx = PARITY;
                    end else begin
                        cnt_nx = bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    state_nx = HUNT;
                    pre_nx   = '0;
                    // Even parity: payload XOR parity bit must be zero.
                    if (^{payload, bit_in}) begin
                        par_err_nx = 1'b1;
                    end else begin
                        load_good = 1'b1;
                    end
                end
                default: begin
                    state_nx = HUNT;
                    pre_nx   = '0;
                end
            endcase
        end
    end

    frame_out_buf #(
        .FRAME_W (FRAME_W)
    ) u_frame_out_buf (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_good),
        .load_data   (payload),
        .frame_ready (frame_ready),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .overrun     (overrun)
    );

endmodule

// File: tb/tb_demod_frame_rx.sv
// Directed bench for demod_frame_rx: good/bad parity, overrun, noise with
// gapped bit_valid, reset mid-frame and a payload containing the preamble.
module tb_demod_frame_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_in;
    logic        bit_valid;
    logic [20:0] frame_out;
    logic        frame_valid;
    logic        frame_ready;
    logic        parity_err;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    int          deliveries   = 0;
    int          valid_cycles = 0;
    int          perr_cnt     = 0;
    int          ovr_cnt      = 0;
    logic [20:0] last_frame   = '0;

    int d0, v0, p0, o0;

    localparam logic [20:0] P1   = 21'b100110011001100110011;
    localparam logic [20:0] F_HI = 21'h1FF800;
    localparam logic [20:0] F_LO = 21'h0007FF;
    localparam logic [20:0] P_A5 = 21'b000000000000010100101;

    demod_frame_rx dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .parity_err  (parity_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) valid_cycles++;
            if (frame_valid && frame_ready) begin
                deliveries++;
                last_frame = frame_out;
            end
            if (parity_err) perr_cnt++;
            if (overrun) ovr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit gap);
        bit_in    = b;
        bit_valid = 1'b1;
        step();
        bit_valid = 1'b0;
        bit_in    = ~b;
        if (gap) step();
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gap);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic send_frame(input logic [20:0] pl, input logic par, input bit gap);
        send_byte(8'hA5, gap);
        for (int i = 20; i >= 0; i--) send_bit(pl[i], gap);
        send_bit(par, gap);
    endtask

    task automatic snap();
        d0 = deliveries; v0 = valid_cycles; p0 = perr_cnt; o0 = ovr_cnt;
    endtask

    initial begin
        rst         = 1'b1;
        bit_in      = 1'b0;
        bit_valid   = 1'b0;
        frame_ready = 1'b1;
        repeat (3) step();
        check("rst_frame_out", 32'(frame_out), 32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        rst = 1'b0;
        step();

        // Good frame, consumer ready
        snap();
        send_frame(P1, 1'b1, 1'b0);
        repeat (3) step();
        check("good_deliveries", 32'(deliveries - d0), 32'd1);
        check("good_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check("good_payload", 32'(last_frame), 32'(P1));
        check("good_perr", 32'(perr_cnt - p0), 32'd0);
        check("good_ovr", 32'(ovr_cnt - o0), 32'd0);

        // Same frame with bad parity
        snap();
        send_frame(P1, 1'b0, 1'b0);
        repeat (3) step();
        check("bad_perr", 32'(perr_cnt - p0), 32'd1);
        check("bad_valid_cycles", 32'(valid_cycles - v0), 32'd0);
        check("bad_deliveries", 32'(deliveries - d0), 32'd0);

        // Back-to-back frames with consumer stalled
        frame_ready = 1'b0;
        snap();
        send_frame(F_HI, 1'b0, 1'b0);
        send_frame(F_LO, 1'b1, 1'b0);
        repeat (3) step();
        check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_held_frame", 32'(frame_out), 32'(F_HI));
        check("ovr_held_valid", 32'(frame_valid), 32'h1);
        check("ovr_perr", 32'(perr_cnt - p0), 32'd0);
        frame_ready = 1'b1;
        repeat (3) step();
        check("drain_deliveries", 32'(deliveries - d0), 32'd1);
        check("drain_payload", 32'(last_frame), 32'(F_HI));
        check("drain_valid", 32'(frame_valid), 32'h0);

        // Noise bytes then a frame, bit_valid toggling every cycle
        snap();
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA4, 1'b1);
        send_frame(P1, 1'b1, 1'b1);
        repeat (3) step();
        check("noise_deliveries", 32'(deliveries - d0), 32'd1);
        check("noise_payload", 32'(last_frame), 32'(P1));
        check("noise_perr", 32'(perr_cnt - p0), 32'd0);

        // Reset after the 10th payload bit, then a full good frame
        snap();
        send_byte(8'hA5, 1'b0);
        for (int i = 20; i >= 11; i--) send_bit(P1[i], 1'b0);
        rst = 1'b1;
        #2;
        check("midrst_valid", 32'(frame_valid), 32'h0);
        check("midrst_frame_out", 32'(frame_out), 32'h0);
        step();
        rst = 1'b0;
        step();
        send_frame(F_LO, 1'b1, 1'b0);
        repeat (3) step();
        check("midrst_deliveries", 32'(deliveries - d0), 32'd1);
        check("midrst_payload", 32'(last_frame), 32'(F_LO));

        // Payload containing the preamble pattern must not resync
        snap();
        send_frame(P_A5, 1'b0, 1'b0);
        repeat (3) step();
        check("a5_deliveries", 32'(deliveries - d0), 32'd1);
        check("a5_payload", 32'(last_frame), 32'(P_A5));
        check("a5_perr", 32'(perr_cnt - p0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
